debug_sweeper: RTL and testbench

DEBUG_SWEEPER -- requirements
Module: debug_sweeper

---
 rtl/debug_sweeper.sv | 160 ++++++++++++++++
 tb/tb_debug_sweeper.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sweeper.sv
// Debug hit generator for TDC calibration: emits hit pulses whose width sweeps
// 1..PERIOD-1 (or stays fixed) once per active period, with idle periods between.
module debug_sweeper #(
    parameter int unsigned PERIOD = 240,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned STEP   = 1,
    parameter int unsigned GAP    = 1,
    parameter int unsigned SWEEPS = 3,
    localparam int unsigned WW    = $clog2(PERIOD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            enabler,
    input  logic [1:0]      mode,
    input  logic [WW-1:0]   fixed_width,
    input  logic [N_CH-1:0] ch_mask,
    output logic [N_CH-1:0] hit,
    output logic [WW-1:0]   cur_width,
    output logic            busy,
    output logic            finished
);

    localparam int unsigned W_MAX = PERIOD - 1;
    localparam int unsigned PW    = $clog2(PERIOD);
    localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned SW    = $clog2(SWEEPS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [PW-1:0]   phase_q;
    logic            act_q;
    logic [GW-1:0]   idle_q;
    logic [WW-1:0]   w_q;
    logic [SW-1:0]   sidx_q;
    logic            en_q;
    logic [1:0]      mode_q;
    logic [N_CH-1:0] hit_q;
    logic [WW-1:0]   cur_width_q;
    logic            busy_q;
    logic            finished_q;

    logic            is_fixed;
    logic [WW-1:0]   fixed_clamp;
    logic [WW-1:0]   width_sel;
    logic [N_CH-1:0] chan_gate;
    logic [N_CH-1:0] gate;
    logic            w_wrap;
    logic [WW-1:0]   w_step;
    logic            last_phase;
    logic            sweeps_done;

    always_comb begin
        is_fixed    = (mode_q == 2'b01);
        fixed_clamp = (32'(fixed_width) > W_MAX) ? WW'(W_MAX) : fixed_width;
        width_sel   = is_fixed ? fixed_clamp : w_q;
        chan_gate   = '1;
        // Rotate mode steers each whole sweep onto a single channel.
        if (mode_q == 2'b10) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                chan_gate[i] = ((32'(sidx_q) % N_CH) == i);
            end
        end
        gate        = ch_mask & chan_gate;
        w_wrap      = (32'(w_q) + STEP) > W_MAX;
        w_step      = w_q + WW'(STEP);
        last_phase  = (32'(phase_q) == PERIOD - 1);
        sweeps_done = !is_fixed && (32'(sidx_q) >= SWEEPS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            act_q       <= 1'b0;
            idle_q      <= '0;
            w_q         <= '0;
            sidx_q      <= '0;
            en_q        <= 1'b0;
            mode_q      <= 2'b00;
            hit_q       <= '0;
            cur_width_q <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start && !stop) begin
                        state_q     <= StRun;
                        phase_q     <= '0;
                        act_q       <= 1'b1;
                        idle_q      <= '0;
                        w_q         <= WW'(1);
                        sidx_q      <= '0;
                        en_q        <= 1'b0;
                        mode_q      <= mode;
                        hit_q       <= '0;
                        cur_width_q <= WW'(1);
                        busy_q      <= 1'b1;
                        finished_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q <= StIdle;
                        hit_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (act_q && phase_q == '0 && sweeps_done) begin
                        // Would-be next active period: the last idle period has ended.
                        state_q    <= StDone;
                        hit_q      <= '0;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end else begin
                        if (!act_q) begin
                            hit_q <= '0;
                        end else if (phase_q == '0) begin
                            en_q        <= enabler;
                            cur_width_q <= width_sel;
                            hit_q       <= (enabler && width_sel != '0) ? gate : '0;
                        end else begin
                            hit_q <= (en_q && 32'(phase_q) < 32'(cur_width_q)) ? gate : '0;
                        end

                        if (last_phase) begin
                            phase_q <= '0;
                            if (act_q) begin
                                if (en_q && !is_fixed) begin
                                    w_q <= w_wrap ? WW'(1) : w_step;
                                    if (w_wrap) begin
                                        sidx_q <= sidx_q + SW'(1);
                                    end
                                end
                                if (GAP != 0) begin
                                    act_q  <= 1'b0;
                                    idle_q <= GW'(GAP - 1);
                                end
                            end else if (idle_q == '0) begin
                                act_q <= 1'b1;
                            end else begin
                                idle_q <= idle_q - GW'(1);
                            end
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hit       = hit_q;
    assign cur_width = cur_width_q;
    assign busy      = busy_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_debug_sweeper.sv
// Directed bench for debug_sweeper: period-arithmetic reference model checked every
// cycle, plus literal timing expectations for sweep, enable gaps, rotate, fixed and abort.
module tb_debug_sweeper;

    localparam int P    = 8;
    localparam int NC   = 2;
    localparam int ST   = 1;
    localparam int G    = 1;
    localparam int SWPS = 2;
    localparam int WMAX = P - 1;
    localparam int WW   = $clog2(P + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          enabler = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [WW-1:0] fixed_width = '0;
    logic [NC-1:0] ch_mask = 2'b11;
    logic [NC-1:0] hit;
    logic [WW-1:0] cur_width;
    logic          busy;
    logic          finished;

    debug_sweeper #(
        .PERIOD(P),
        .N_CH  (NC),
        .STEP  (ST),
        .GAP   (G),
        .SWEEPS(SWPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .enabler    (enabler),
        .mode       (mode),
        .fixed_width(fixed_width),
        .ch_mask    (ch_mask),
        .hit        (hit),
        .cur_width  (cur_width),
        .busy       (busy),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: run position is tracked as a cycle count since the start edge.
    int          m_state = 0;  // 0 idle, 1 run, 2 done
    int          m_t = 0;
    logic [1:0]  m_mode = 2'b00;
    int          m_w = 0;
    int          m_sidx = 0;
    int          m_cw = 0;
    logic        m_en = 1'b0;
    logic [NC-1:0] m_hit = '0;

    task automatic model_step();
        int  p;
        int  ph;
        bit  act;
        bit  fixed;
        if (rst) begin
            m_state = 0; m_cw = 0; m_hit = '0; m_w = 0; m_sidx = 0;
        end else if (m_state != 1) begin
            if (start && !stop) begin
                m_state = 1; m_t = 0; m_mode = mode; m_w = 1; m_sidx = 0;
                m_cw = 1; m_hit = '0; m_en = 1'b0;
            end
        end else if (stop) begin
            m_state = 0; m_hit = '0;
        end else begin
            m_t++;
            p     = (m_t - 1) / P;
            ph    = (m_t - 1) % P;
            act   = (p % (G + 1)) == 0;
            fixed = (m_mode == 2'b01);
            if (act && ph == 0 && !fixed && m_sidx >= SWPS) begin
                m_state = 2; m_hit = '0;
            end else begin
                if (act && ph == 0) begin
                    m_en = enabler;
                    m_cw = fixed ? ((int'(fixed_width) > WMAX) ? WMAX : int'(fixed_width)) : m_w;
                end
                m_hit = '0;
                if (act && m_en && ph < m_cw) begin
                    for (int i = 0; i < NC; i++) begin
                        m_hit[i] = ch_mask[i] && (m_mode != 2'b10 || (m_sidx % NC) == i);
                    end
                end
                if (act && ph == P - 1 && m_en && !fixed) begin
                    m_w += ST;
                    if (m_w > WMAX) begin
                        m_w = 1;
                        m_sidx++;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            chk("model_hit", 32'(hit), 32'(m_hit));
            chk("model_cur_width", 32'(cur_width), 32'(m_cw));
            chk("model_busy", 32'(busy), 32'(m_state == 1));
            chk("model_finished", 32'(finished), 32'(m_state == 2));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [1:0] md, output int k);
        mode  = md;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k     = cyc;
    endtask

    task automatic wait_fin();
        int n = 0;
        while (!finished && n < 400) begin
            tick(1);
            n++;
        end
    endtask

    int          k;
    int          cnt;
    logic [NC-1:0] or0;
    logic [NC-1:0] or1;

    initial begin
        tick(3);
        rst = 1'b0;
        chk("reset_hit", 32'(hit), 0);
        chk("reset_cur_width", 32'(cur_width), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_finished", 32'(finished), 0);
        tick(2);

        // Plain sweep, both channels
        launch(2'b00, k);
        chk("start_cycle_busy", 32'(busy), 1);
        chk("start_cycle_hit", 32'(hit), 0);
        tick(1);
        chk("p1_hit", 32'(hit), 32'h3);
        chk("p1_width", 32'(cur_width), 1);
        tick(1);
        chk("p1_hit_end", 32'(hit), 0);
        tick(15);
        chk("p3_width", 32'(cur_width), 2);
        chk("p3_hit0", 32'(hit), 32'h3);
        tick(1);
        chk("p3_hit1", 32'(hit), 32'h3);
        tick(1);
        chk("p3_hit_end", 32'(hit), 0);
        wait_fin();
        chk("sweep_done_cycle", 32'(cyc - k), 225);
        chk("done_width", 32'(cur_width), 7);
        chk("done_busy", 32'(busy), 0);

        // Restart from DONE, with enabler low at period 3 start
        launch(2'b00, k);
        chk("restart_finished", 32'(finished), 0);
        chk("restart_width", 32'(cur_width), 1);
        tick(16);
        enabler = 1'b0;
        tick(1);
        chk("disabled_p3_hit", 32'(hit), 0);
        enabler = 1'b1;
        tick(16);
        chk("p5_width", 32'(cur_width), 2);
        chk("p5_hit0", 32'(hit), 32'h3);
        tick(2);
        chk("p5_hit_end", 32'(hit), 0);
        wait_fin();
        chk("gap_done_cycle", 32'(cyc - k), 241);

        // Rotate-sweep
        launch(2'b10, k);
        or0 = '0;
        or1 = '0;
        for (int i = 0; i < 224; i++) begin
            tick(1);
            if (cyc - k <= 112) or0 |= hit;
            else or1 |= hit;
        end
        chk("rotate_sweep0_chan", 32'(or0), 32'h1);
        chk("rotate_sweep1_chan", 32'(or1), 32'h2);
        tick(1);
        chk("rotate_finished", 32'(finished), 1);

        // Fixed width, clamped to PERIOD-1
        fixed_width = 4'd12;
        launch(2'b01, k);
        tick(1);
        chk("fixed_width_clamp", 32'(cur_width), 7);
        cnt = int'(hit[0]);
        for (int i = 0; i < 63; i++) begin
            tick(1);
            cnt += int'(hit[0]);
        end
        chk("fixed_hits_64cyc", 32'(cnt), 28);
        tick(200);
        chk("fixed_never_done", 32'(finished), 0);
        chk("fixed_still_busy", 32'(busy), 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("fixed_stopped", 32'(busy), 0);

        // Stop during cycle k+20
        launch(2'b01, k);
        tick(20);
        chk("pre_stop_hit", 32'(hit), 32'h3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_hit", 32'(hit), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_finished", 32'(finished), 0);
        chk("stop_width_holds", 32'(cur_width), 7);

        // start together with stop
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", 32'(busy), 0);
        tick(3);
        chk("start_stop_idle_later", 32'(busy), 0);

        // Fixed width 0
        fixed_width = '0;
        launch(2'b01, k);
        or0 = '0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            or0 |= hit;
        end
        chk("fixed_zero_no_hit", 32'(or0), 0);
        chk("fixed_zero_busy", 32'(busy), 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;

        // Asynchronous reset mid-pulse
        fixed_width = 4'd12;
        launch(2'b01, k);
        tick(5);
        chk("pre_rst_hit", 32'(hit), 32'h3);
        rst = 1'b1;
        #1;
        chk("async_rst_hit", 32'(hit), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_width", 32'(cur_width), 0);
        chk("async_rst_finished", 32'(finished), 0);
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("post_rst_needs_start", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
